// File: rtl/axi4_lite_csr_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite CSR block.
package axi4_lite_csr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_ADDR_DATA = 1'b0,
    WR_RESP      = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_ADDR = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_csr.sv
// AXI4-Lite register file: RW control registers followed by RO status words.
// Optional AXI4_LITE_CSR_WR_PULSE_EN adds a per-register write strobe output.
module axi4_lite_csr
  import axi4_lite_csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RW_CNT     = 8,
  parameter int unsigned RO_CNT     = 4
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  axi4_lite_if.slave                         csr_if,
  output logic [RW_CNT-1:0][DATA_WIDTH-1:0]  ctrl_o,
  input  logic [RO_CNT-1:0][DATA_WIDTH-1:0]  stat_i
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
  ,
  output logic [RW_CNT-1:0]                  wr_pulse_o
`endif
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;

  function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr >> ADDR_LSB;
  endfunction

  wr_state_t                         wr_state_q, wr_state_d;
  logic                              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                              awready_q, awready_d, wready_q, wready_d;
  logic                              bvalid_q, bvalid_d;
  logic [1:0]                        bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]             waddr_q, waddr_d, wr_idx;
  logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
  logic [STRB_W-1:0]                 wstrb_q, wstrb_d;
  logic [RW_CNT-1:0][DATA_WIDTH-1:0] ctrl_q, ctrl_d;

  rd_state_t                         rd_state_q, rd_state_d;
  logic                              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;
  logic [1:0]                        rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0]             rd_idx;

`ifdef AXI4_LITE_CSR_WR_PULSE_EN
  logic [RW_CNT-1:0]                 wr_pulse_q, wr_pulse_d;
`endif

  // Protection attributes carry no meaning for this register file.
  logic unused_prot_c;
  assign unused_prot_c = ^{csr_if.awprot, csr_if.arprot};

  // Write path: collect AW and W independently, commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    wr_idx     = word_idx(waddr_q);
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
    wr_pulse_d = '0;
`endif
    case (wr_state_q)
      WR_ADDR_DATA: begin
        if (aw_held_q && w_held_q) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_SLVERR;
          wr_state_d = WR_RESP;
          for (int unsigned i = 0; i < RW_CNT; i++) begin
            if (wr_idx == ADDR_WIDTH'(i)) begin
              bresp_d = RESP_OKAY;
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
              wr_pulse_d[i] = 1'b1;
`endif
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) ctrl_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
              end
            end
          end
        end else begin
          if (csr_if.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            waddr_d   = csr_if.awaddr;
          end
          if (csr_if.wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = csr_if.wdata;
            wstrb_d  = csr_if.wstrb;
          end
        end
      end
      WR_RESP: begin
        if (csr_if.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_ADDR_DATA;
        end
      end
      default: wr_state_d = WR_ADDR_DATA;
    endcase
    awready_d = (wr_state_d == WR_ADDR_DATA) && !aw_held_d;
    wready_d  = (wr_state_d == WR_ADDR_DATA) && !w_held_d;
  end

  // Read path: the value is sampled at the AR handshake, before any same-cycle write lands.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_idx     = word_idx(csr_if.araddr);
    case (rd_state_q)
      RD_ADDR: begin
        if (csr_if.arvalid && arready_q) begin
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
          for (int unsigned i = 0; i < RW_CNT; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
              rdata_d = ctrl_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          for (int unsigned j = 0; j < RO_CNT; j++) begin
            if (rd_idx == ADDR_WIDTH'(RW_CNT + j)) begin
              rdata_d = stat_i[j];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      RD_RESP: begin
        if (csr_if.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_ADDR;
        end
      end
      default: rd_state_d = RD_ADDR;
    endcase
    arready_d = (rd_state_d == RD_ADDR);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_ADDR_DATA;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ctrl_q     <= '0;
      rd_state_q <= RD_ADDR;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
      wr_pulse_q <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ctrl_q     <= ctrl_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
      wr_pulse_q <= wr_pulse_d;
`endif
    end
  end

  assign csr_if.awready = awready_q;
  assign csr_if.wready  = wready_q;
  assign csr_if.bvalid  = bvalid_q;
  assign csr_if.bresp   = bresp_q;
  assign csr_if.arready = arready_q;
  assign csr_if.rvalid  = rvalid_q;
  assign csr_if.rdata   = rdata_q;
  assign csr_if.rresp   = rresp_q;
  assign ctrl_o         = ctrl_q;
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
  assign wr_pulse_o     = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axi4_lite_csr.sv
// Directed self-checking bench for axi4_lite_csr (default 16-bit address, 32-bit data, 8 RW, 4 RO).
module tb_axi4_lite_csr;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned RWN = 8;
  localparam int unsigned RON = 4;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [RWN-1:0][DW-1:0] ctrl;
  logic [RON-1:0][DW-1:0] stat;
  logic [RWN-1:0][DW-1:0] exp_ctrl;
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
  logic [RWN-1:0]         wr_pulse;
`endif

  axi4_lite_csr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_CNT(RWN), .RO_CNT(RON)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .csr_if    (bus),
    .ctrl_o    (ctrl),
    .stat_i    (stat)
`ifdef AXI4_LITE_CSR_WR_PULSE_EN
    ,
    .wr_pulse_o(wr_pulse)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Full write transaction; aw_dly/w_dly set per-channel start cycle, nb counts bvalid beats seen.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp, output int nb);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs;
    int cyc = 0;
    resp = 2'bxx;
    nb   = 0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.bready = 1'b1;
    while (!b_done && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      if (bus.bvalid) begin
        resp   = bus.bresp;
        nb++;
        b_done = 1;
      end
      @(posedge aclk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!b_done) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout addr=%h: no bvalid within 40 cycles", addr);
    end
    repeat (2) begin
      if (bus.bvalid) nb++;
      @(posedge aclk); #1;
    end
    bus.bready = 1'b0;
  endtask

  // Full read transaction; hold = cycles rready stays low once rvalid is seen.
  task automatic axi_read(input logic [15:0] addr, input int hold, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit stable);
    int cyc = 0;
    bit hs  = 0;
    data   = 'x;
    resp   = 'x;
    lat    = 1;
    stable = 1;
    bus.araddr = addr;
    bus.rready = 1'b0;
    while (!hs && cyc < 40) begin
      bus.arvalid = 1'b1;
      hs = bus.arready;
      @(posedge aclk); #1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    cyc = 0;
    while (!bus.rvalid && cyc < 40) begin
      @(posedge aclk); #1;
      lat++;
      cyc++;
    end
    if (!bus.rvalid) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout addr=%h: no rvalid within 40 cycles", addr);
      stable = 0;
    end else begin
      data = bus.rdata;
      resp = bus.rresp;
      repeat (hold) begin
        @(posedge aclk); #1;
        if (bus.rvalid !== 1'b1 || bus.rdata !== data || bus.rresp !== resp) stable = 0;
      end
      bus.rready = 1'b1;
      @(posedge aclk); #1;
      bus.rready = 1'b0;
      if (bus.rvalid !== 1'b0) stable = 0;
    end
  endtask

  task automatic test_reset();
    #2 aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    n_tests++;
    if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got=%h want=0", ctrl); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=111", {bus.awready, bus.wready, bus.arready});
    end
    exp_ctrl = '0;
  endtask

  task automatic test_write_basic();
    logic [1:0] resp; int nb;
    axi_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 2, resp, nb);
    exp_ctrl[1] = 32'hDEADBEEF;
    n_tests++;
    if (ctrl[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_basic_data got=%h want=deadbeef", ctrl[1]); end
    n_tests++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL wr_basic_resp got=%b want=00", resp); end
    n_tests++;
    if (nb !== 1) begin n_fail++; $display("FAIL wr_basic_bcount got=%0d want=1", nb); end
  endtask

  task automatic test_write_order();
    logic [1:0] resp; int nb;
    axi_write(16'h0008, 32'h12345678, 4'b0101, 2, 0, resp, nb);
    exp_ctrl[2] = 32'h00340078;
    n_tests++;
    if (ctrl[2] !== 32'h00340078 || resp !== 2'b00) begin
      n_fail++; $display("FAIL wr_w_first got=%h/%b want=00340078/00", ctrl[2], resp);
    end
    axi_write(16'h000C, 32'h12345678, 4'b0101, 0, 0, resp, nb);
    exp_ctrl[3] = 32'h00340078;
    n_tests++;
    if (ctrl[3] !== 32'h00340078 || nb !== 1) begin
      n_fail++; $display("FAIL wr_same_cycle got=%h/%0d want=00340078/1", ctrl[3], nb);
    end
    axi_write(16'h000E, 32'hFFFFFFFF, 4'b1000, 0, 0, resp, nb);
    exp_ctrl[3] = 32'hFF340078;
    n_tests++;
    if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL wr_byte_offset got=%h want=%h", ctrl, exp_ctrl); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; int nb;
    axi_write(16'h0020, 32'h11111111, 4'hF, 0, 0, resp, nb);
    n_tests++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL wr_ro_resp got=%b want=10", resp); end
    axi_write(16'h0100, 32'h22222222, 4'hF, 1, 0, resp, nb);
    n_tests++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL wr_oor_resp got=%b want=10", resp); end
    n_tests++;
    if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL wr_err_unchanged got=%h want=%h", ctrl, exp_ctrl); end
  endtask

  task automatic test_read();
    logic [31:0] d; logic [1:0] r; int lat; bit st;
    axi_read(16'h0020, 5, d, r, lat, st);
    n_tests++;
    if (d !== 32'hA5A5A5A5 || r !== 2'b00) begin
      n_fail++; $display("FAIL rd_stat0 got=%h/%b want=a5a5a5a5/00", d, r);
    end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL rd_latency got=%0d want=1", lat); end
    n_tests++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL rd_stable got=%b want=1", st); end
    axi_read(16'h0100, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_oor got=%h/%b want=0/10", d, r); end
    axi_read(16'h002C, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h5A5A0F0F || r !== 2'b00) begin
      n_fail++; $display("FAIL rd_stat3 got=%h/%b want=5a5a0f0f/00", d, r);
    end
    axi_read(16'h000D, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'hFF340078 || r !== 2'b00) begin
      n_fail++; $display("FAIL rd_ctrl3 got=%h/%b want=ff340078/00", d, r);
    end
  endtask

  task automatic test_rw_collision();
    logic [1:0] resp; int nb; logic [31:0] d; logic [1:0] r; int lat; bit st;
    axi_write(16'h0000, 32'h1, 4'hF, 0, 0, resp, nb);
    exp_ctrl[0] = 32'h1;
    bus.awaddr  = 16'h0000;
    bus.wdata   = 32'h2;
    bus.wstrb   = 4'hF;
    bus.araddr  = 16'h0000;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    n_tests++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) begin
      n_fail++; $display("FAIL collision_old got=%b/%h want=1/00000001", bus.rvalid, bus.rdata);
    end
    n_tests++;
    if (ctrl[0] !== 32'h2 || bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      n_fail++; $display("FAIL collision_write got=%h/%b/%b want=00000002/1/00", ctrl[0], bus.bvalid, bus.bresp);
    end
    exp_ctrl[0] = 32'h2;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    axi_read(16'h0000, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL collision_next got=%h want=00000002", d); end
  endtask

  task automatic test_reset_in_wresp();
    logic [1:0] resp; int nb;
    bus.awaddr  = 16'h0004;
    bus.wdata   = 32'h0BADF00D;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_tests++;
    if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_bvalid got=%b want=1", bus.bvalid); end
    aresetn = 1'b0;
    #1;
    n_tests++;
    if (bus.bvalid !== 1'b0 || ctrl !== '0 || bus.awready !== 1'b0) begin
      n_fail++; $display("FAIL rst_async got=%b/%h/%b want=0/0/0", bus.bvalid, ctrl, bus.awready);
    end
    exp_ctrl = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    axi_write(16'h0010, 32'hCAFEF00D, 4'hF, 0, 0, resp, nb);
    exp_ctrl[4] = 32'hCAFEF00D;
    n_tests++;
    if (resp !== 2'b00 || nb !== 1 || ctrl !== exp_ctrl) begin
      n_fail++; $display("FAIL rst_next_write got=%b/%0d/%h want=00/1/%h", resp, nb, ctrl, exp_ctrl);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; int nb; logic [31:0] d; logic [1:0] r; int lat; bit st;
    logic [31:0] want;
    for (int i = 5; i < 8; i++) begin
      want = 32'h1000_0000 | 32'(i * 32'h0101);
      axi_write(16'(i * 4), want, 4'hF, 0, 0, resp, nb);
      exp_ctrl[i] = want;
    end
    for (int i = 5; i < 8; i++) begin
      axi_read(16'(i * 4), 0, d, r, lat, st);
      n_tests++;
      if (d !== exp_ctrl[i] || r !== 2'b00) begin
        n_fail++; $display("FAIL b2b_read%0d got=%h/%b want=%h/00", i, d, r, exp_ctrl[i]);
      end
    end
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b0;
    bus.rready  = 1'b0;
    stat[0] = 32'hA5A5A5A5;
    stat[1] = 32'h01020304;
    stat[2] = 32'h00000000;
    stat[3] = 32'h5A5A0F0F;
    exp_ctrl = '0;
    test_reset();
    test_write_basic();
    test_write_order();
    test_slverr();
    test_read();
    test_rw_collision();
    test_reset_in_wresp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
